// File: rtl/pmod_als_sensor_model_pkg.sv
// Purpose : shared frame constants and state type for the Pmod ALS sensor model and its receiver.
// Latency : n/a (type and constant definitions only).
// Backpressure: n/a.
package pmod_als_pkg;

    localparam int ALS_DATA_BITS  = 8;   // width of the light sample
    localparam int ALS_FRAME_BITS = 16;  // SCK cycles per frame
    localparam int ALS_LEAD_ZEROS = 3;   // zero bits ahead of the sample

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } als_state_t;

endpackage

// File: rtl/pmod_als_sensor_model_if.sv
// Purpose : SPI-side bundle between the light-sensor model and whoever drives cs/sck and the sample.
// Latency : n/a (wiring only).
// Backpressure: none; the master paces everything through cs/sck.
// Ports   : light/light_valid (sample load), cs/sck (from master), sdo/sdo_en (to master),
//           frame_done/frame_abort (status pulses).
interface pmod_als_sensor_model_if
    import pmod_als_pkg::*;
#(
    parameter int DATA_BITS = ALS_DATA_BITS
);
    logic [DATA_BITS-1:0] light;
    logic                 light_valid;
    logic                 cs;
    logic                 sck;
    logic                 sdo;
    logic                 sdo_en;
    logic                 frame_done;
    logic                 frame_abort;

    modport master (
        output light, light_valid, cs, sck,
        input  sdo, sdo_en, frame_done, frame_abort
    );

    modport slave (
        input  light, light_valid, cs, sck,
        output sdo, sdo_en, frame_done, frame_abort
    );
endinterface

// File: rtl/pmod_als_sensor_model_sync_edge_detect.sv
// Purpose : 2-flop synchroniser plus edge-detect register for one asynchronous pin.
// Latency : rise/fall pulse valid 2-3 clock cycles after the pin edge, one cycle wide.
// Backpressure: none.
// Ports   : clock, reset (sync, active-high), din (async pin), rise/fall (single-cycle pulses).
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Whole history resets to the idle level so leaving reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/pmod_als_sensor_model.sv
// Purpose : SPI responder emulating the Pmod ALS (ADC081S021) 16-bit frame from a held light sample.
// Latency : sdo/sdo_en settle within 3 clocks of a pin sck/cs fall; done/abort pulse 3 clocks after cs rise.
// Backpressure: none; sck phases and cs setup must each be >= 4 clock periods.
// Ports   : clock, reset (sync, active-high), bus (slave modport: light, light_valid, cs, sck in;
//           sdo, sdo_en, frame_done, frame_abort out).
module pmod_als_sensor_model
    import pmod_als_pkg::*;
#(
    parameter int DATA_BITS  = ALS_DATA_BITS,
    parameter int FRAME_BITS = ALS_FRAME_BITS,
    parameter int LEAD_ZEROS = ALS_LEAD_ZEROS
) (
    input  logic                     clock,
    input  logic                     reset,
    pmod_als_sensor_model_if.slave   bus
);
    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
    localparam int CNT_W       = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic                  cs_rise;
    logic                  cs_fall;
    logic                  sck_rise;
    logic                  sck_fall;

    als_state_t            state;
    logic [DATA_BITS-1:0]  light_hold;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_init;
    logic [CNT_W-1:0]      rise_cnt;
    logic                  done_q;
    logic                  abort_q;

    sync_edge_detect #(.RESET_VAL(1'b1)) u_cs_sync (
        .clock (clock),
        .reset (reset),
        .din   (bus.cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_sck_sync (
        .clock (clock),
        .reset (reset),
        .din   (bus.sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // Leading zeros, sample MSB first, trailing zeros.
    assign frame_init = FRAME_BITS'(light_hold) << TRAIL_ZEROS;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            light_hold <= '0;
            shreg      <= '0;
            rise_cnt   <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // The frame is copied into shreg at cs fall, so a load here never touches
            // the frame in flight; a load on the same cycle as cs fall lands afterwards.
            if (bus.light_valid) begin
                light_hold <= bus.light;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg    <= frame_init;
                        rise_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs rise takes priority over any sck edge seen in the same cycle.
                    if (cs_rise) begin
                        state <= IDLE;
                        shreg <= '0;
                        if (rise_cnt == CNT_FULL) begin
                            done_q <= 1'b1;
                        end else begin
                            abort_q <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        // Zero fill keeps sdo low for any edges past the last bit.
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end else if (sck_rise && (rise_cnt != CNT_FULL)) begin
                        rise_cnt <= rise_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // shreg is cleared whenever the FSM is in IDLE, so sdo is 0 there.
    assign bus.sdo         = shreg[FRAME_BITS-1];
    assign bus.sdo_en      = (state == SHIFT);
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;
endmodule
